// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
//   Shared types for the five-stage pipeline latch bank.
//   ctrl_t      : 8-bit decoded control word, MSB first
//                 {RegWr, MemtoReg, memWr, bneS, beqS, jS, jrS, jalS}
//   pipe_slot_t : one ID/EX, EX/MEM or MEM/WB latch (88 bits)
//   BUBBLE_SLOT : all-zero slot, valid = 0
//   PC_RESET    : PC value loaded on reset
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef struct packed {
        logic reg_wr;
        logic mem_to_reg;
        logic mem_wr;
        logic bne_s;
        logic beq_s;
        logic j_s;
        logic jr_s;
        logic jal_s;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        ctrl_t       ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } pipe_slot_t;

    localparam pipe_slot_t  BUBBLE_SLOT = '0;
    localparam logic [31:0] PC_RESET    = 32'h0000_0000;

    // Builds the ID/EX load value from the IF/ID contents and decode output.
    function automatic pipe_slot_t make_slot(input logic [31:0] instr,
                                             input logic [31:0] npc,
                                             input ctrl_t       ctrl);
        pipe_slot_t s;
        s.instr = instr;
        s.npc   = npc;
        s.valid = 1'b1;
        s.ctrl  = ctrl;
        s.rs    = instr[25:21];
        s.rt    = instr[20:16];
        s.rd    = instr[15:11];
        return s;
    endfunction

endpackage

// File: rtl/pipeline_latches_if.sv
// ---------------------------------------------------------------------------
// pipeline_latches_if
//   Bundle between fetch/decode/hazard unit and the pipeline latch bank.
//   slave  : the latch bank (takes commands and fetch data, drives latch
//            contents and hazard taps)
//   master : the surrounding pipeline logic
//   With PIPE_STATS_EN defined, bubble_cnt/flush_cnt are added as outputs.
// ---------------------------------------------------------------------------
interface pipeline_latches_if;
    import cpu_types_pkg::*;

    // commands and fetch/decode data
    logic        pipe_en;
    logic [31:0] next_pc;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_npc;
    logic [7:0]  dec_ctrl;
    logic        PCWrite;
    logic        fdif_stall, fdif_flush;
    logic        deif_stall, deif_flush;
    logic        emif_stall, emif_flush;
    logic        mwif_stall, mwif_flush;

    // latch contents
    logic [31:0] pc;
    logic [31:0] fd_instr, fd_npc;
    pipe_slot_t  de_slot, em_slot, mw_slot;

    // hazard unit taps
    logic [4:0]  fdif_rs, fdif_rt, fdif_rd;
    logic [4:0]  deif_rs, deif_rt, deif_rd;
    logic [4:0]  emif_rs, emif_rt, emif_rd;
    logic        deif_RegWr, deif_MemtoReg, deif_memWr;
    logic        emif_RegWr, emif_MemtoReg, emif_bneS, emif_beqS;
    logic        emif_jS, emif_jrS, emif_jalS;

`ifdef PIPE_STATS_EN
    logic [31:0] bubble_cnt, flush_cnt;
`endif

    modport slave (
        input  pipe_en, next_pc, fetch_instr, fetch_npc, dec_ctrl, PCWrite,
               fdif_stall, fdif_flush, deif_stall, deif_flush,
               emif_stall, emif_flush, mwif_stall, mwif_flush,
        output pc, fd_instr, fd_npc, de_slot, em_slot, mw_slot,
               fdif_rs, fdif_rt, fdif_rd, deif_rs, deif_rt, deif_rd,
               emif_rs, emif_rt, emif_rd,
               deif_RegWr, deif_MemtoReg, deif_memWr,
               emif_RegWr, emif_MemtoReg, emif_bneS, emif_beqS,
               emif_jS, emif_jrS, emif_jalS
`ifdef PIPE_STATS_EN
               , bubble_cnt, flush_cnt
`endif
    );

    modport master (
        output pipe_en, next_pc, fetch_instr, fetch_npc, dec_ctrl, PCWrite,
               fdif_stall, fdif_flush, deif_stall, deif_flush,
               emif_stall, emif_flush, mwif_stall, mwif_flush,
        input  pc, fd_instr, fd_npc, de_slot, em_slot, mw_slot,
               fdif_rs, fdif_rt, fdif_rd, deif_rs, deif_rt, deif_rd,
               emif_rs, emif_rt, emif_rd,
               deif_RegWr, deif_MemtoReg, deif_memWr,
               emif_RegWr, emif_MemtoReg, emif_bneS, emif_beqS,
               emif_jS, emif_jrS, emif_jalS
`ifdef PIPE_STATS_EN
               , bubble_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/pipe_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
//   One pipe_slot_t stage register.
//   Ports: CLK, nRST (async, active-low), en (global advance), flush/stall
//   (this stage), up_stall/up_flush (upstream stage), slot_in (upstream
//   contents), slot_q (this stage's contents).
//   Priority: flush > stall (hold) > bubble behind a held upstream > load.
// ---------------------------------------------------------------------------
module pipe_stage
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic       en,
    input  logic       flush,
    input  logic       stall,
    input  logic       up_stall,
    input  logic       up_flush,
    input  pipe_slot_t slot_in,
    output pipe_slot_t slot_q
);

    pipe_slot_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (flush)
            slot_d = BUBBLE_SLOT;
        else if (stall)
            slot_d = slot_q;
        // Upstream is holding its contents, so pass nothing downstream.
        // A flushed upstream forwards its pre-flush contents instead.
        else if (up_stall && !up_flush)
            slot_d = BUBBLE_SLOT;
        else
            slot_d = slot_in;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            slot_q <= BUBBLE_SLOT;
        else if (en)
            slot_q <= slot_d;
    end

endmodule

// File: rtl/pipeline_latches.sv
// ---------------------------------------------------------------------------
// pipeline_latches
//   Stage-register bank: PC, IF/ID, ID/EX, EX/MEM, MEM/WB. Applies the
//   hazard unit's PCWrite/stall/flush commands and drives its field taps.
//   Ports: CLK, nRST (async, active-low), bus (pipeline_latches_if.slave).
//   Optional: PIPE_STATS_EN adds saturating bubble_cnt / flush_cnt.
// ---------------------------------------------------------------------------
module pipeline_latches
    import cpu_types_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    pipeline_latches_if.slave  bus
);

    localparam int NUM_STAGES = 3;  // ID/EX, EX/MEM, MEM/WB

    logic [31:0] pc_q, fd_instr_q, fd_npc_q;

    // index 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB
    logic [NUM_STAGES:0] stall_v, flush_v;

    pipe_slot_t [NUM_STAGES-1:0] slot_src, slot_q;

    assign stall_v = {bus.mwif_stall, bus.emif_stall, bus.deif_stall, bus.fdif_stall};
    assign flush_v = {bus.mwif_flush, bus.emif_flush, bus.deif_flush, bus.fdif_flush};

    // PC and IF/ID
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q       <= PC_RESET;
            fd_instr_q <= '0;
            fd_npc_q   <= '0;
        end else if (bus.pipe_en) begin
            if (bus.PCWrite)
                pc_q <= bus.next_pc;
            if (bus.fdif_flush) begin
                fd_instr_q <= '0;
                fd_npc_q   <= '0;
            end else if (!bus.fdif_stall) begin
                fd_instr_q <= bus.fetch_instr;
                fd_npc_q   <= bus.fetch_npc;
            end
        end
    end

    // ID/EX .. MEM/WB
    assign slot_src[0] = make_slot(fd_instr_q, fd_npc_q, ctrl_t'(bus.dec_ctrl));

    for (genvar i = 1; i < NUM_STAGES; i++) begin : g_src
        assign slot_src[i] = slot_q[i-1];
    end

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        pipe_stage u_stage (
            .CLK      (CLK),
            .nRST     (nRST),
            .en       (bus.pipe_en),
            .flush    (flush_v[i+1]),
            .stall    (stall_v[i+1]),
            .up_stall (stall_v[i]),
            .up_flush (flush_v[i]),
            .slot_in  (slot_src[i]),
            .slot_q   (slot_q[i])
        );
    end

    assign bus.pc       = pc_q;
    assign bus.fd_instr = fd_instr_q;
    assign bus.fd_npc   = fd_npc_q;
    assign bus.de_slot  = slot_q[0];
    assign bus.em_slot  = slot_q[1];
    assign bus.mw_slot  = slot_q[2];

    // hazard taps
    assign bus.fdif_rs = fd_instr_q[25:21];
    assign bus.fdif_rt = fd_instr_q[20:16];
    assign bus.fdif_rd = fd_instr_q[15:11];
    assign bus.deif_rs = slot_q[0].rs;
    assign bus.deif_rt = slot_q[0].rt;
    assign bus.deif_rd = slot_q[0].rd;
    assign bus.emif_rs = slot_q[1].rs;
    assign bus.emif_rt = slot_q[1].rt;
    assign bus.emif_rd = slot_q[1].rd;

    assign bus.deif_RegWr    = slot_q[0].ctrl.reg_wr;
    assign bus.deif_MemtoReg = slot_q[0].ctrl.mem_to_reg;
    assign bus.deif_memWr    = slot_q[0].ctrl.mem_wr;
    assign bus.emif_RegWr    = slot_q[1].ctrl.reg_wr;
    assign bus.emif_MemtoReg = slot_q[1].ctrl.mem_to_reg;
    assign bus.emif_bneS     = slot_q[1].ctrl.bne_s;
    assign bus.emif_beqS     = slot_q[1].ctrl.beq_s;
    assign bus.emif_jS       = slot_q[1].ctrl.j_s;
    assign bus.emif_jrS      = slot_q[1].ctrl.jr_s;
    assign bus.emif_jalS     = slot_q[1].ctrl.jal_s;

`ifdef PIPE_STATS_EN
    logic [31:0]           bubble_cnt_q, flush_cnt_q;
    logic [NUM_STAGES-1:0] bubble_v;

    // Mirrors the bubble-insertion rule of each stage: only counted when
    // neither this stage's flush nor its own stall takes precedence.
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_bub
        assign bubble_v[i] = !flush_v[i+1] && !stall_v[i+1] && stall_v[i] && !flush_v[i];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else if (bus.pipe_en) begin
            if (|bubble_v && bubble_cnt_q != '1)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (|flush_v && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_latches.sv
module tb_pipeline_latches;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   checks = 0;
    int   errors = 0;

    pipeline_latches_if bus();

    pipeline_latches dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // all hazard-unit taps concatenated (45 field bits + 10 control bits)
    function automatic logic [54:0] hz_taps();
        return {bus.fdif_rs, bus.fdif_rt, bus.fdif_rd, bus.deif_rs, bus.deif_rt, bus.deif_rd,
                bus.emif_rs, bus.emif_rt, bus.emif_rd,
                bus.deif_RegWr, bus.deif_MemtoReg, bus.deif_memWr,
                bus.emif_RegWr, bus.emif_MemtoReg, bus.emif_bneS, bus.emif_beqS,
                bus.emif_jS, bus.emif_jrS, bus.emif_jalS};
    endfunction

    task automatic set_idle();
        bus.pipe_en     = 1'b1;
        bus.PCWrite     = 1'b1;
        bus.next_pc     = '0;
        bus.fetch_instr = '0;
        bus.fetch_npc   = '0;
        bus.dec_ctrl    = '0;
        bus.fdif_stall  = 1'b0; bus.fdif_flush = 1'b0;
        bus.deif_stall  = 1'b0; bus.deif_flush = 1'b0;
        bus.emif_stall  = 1'b0; bus.emif_flush = 1'b0;
        bus.mwif_stall  = 1'b0; bus.mwif_flush = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        nRST = 1'b0;
        #2;
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", bus.pc, 32'h0); end
        checks++; if (bus.fd_instr !== 32'h0) begin errors++; $display("FAIL reset_fd got %h exp 0", bus.fd_instr); end
        checks++; if ({bus.de_slot, bus.em_slot, bus.mw_slot} !== '0) begin errors++; $display("FAIL reset_slots not bubble"); end
        checks++; if (hz_taps() !== 55'h0) begin errors++; $display("FAIL reset_hz got %h exp 0", hz_taps()); end
`ifdef PIPE_STATS_EN
        checks++; if ({bus.bubble_cnt, bus.flush_cnt} !== 64'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", {bus.bubble_cnt, bus.flush_cnt}); end
`endif
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // lw, add, lw, beq with their decoded control words
    task automatic test_stream();
        logic [31:0] instrs [4];
        logic [7:0]  ctrls  [4];
        instrs = '{32'h8C22_0004, 32'h00A6_2020, 32'h8C43_0008, 32'h1022_0003};
        ctrls  = '{8'hC0, 8'h80, 8'hC0, 8'h08};
        for (int k = 0; k < 4; k++) begin
            bus.fetch_instr = instrs[k];
            bus.fetch_npc   = 32'(4 * (k + 1));
            bus.next_pc     = 32'(4 * (k + 1));
            bus.dec_ctrl    = (k > 0) ? ctrls[k-1] : 8'h00;
            step();
            if (k == 2) begin
                checks++; if (bus.em_slot.instr !== 32'h8C22_0004) begin errors++; $display("FAIL stream_em_instr got %h exp 8c220004", bus.em_slot.instr); end
                checks++; if ({bus.emif_rs, bus.emif_rt} !== {5'd1, 5'd2}) begin errors++; $display("FAIL stream_em_rsrt got %h exp %h", {bus.emif_rs, bus.emif_rt}, {5'd1, 5'd2}); end
                checks++; if (bus.emif_MemtoReg !== 1'b1) begin errors++; $display("FAIL stream_em_memtoreg got %b exp 1", bus.emif_MemtoReg); end
            end
        end
        checks++; if (bus.mw_slot.instr !== 32'h8C22_0004 || bus.mw_slot.npc !== 32'd4 || bus.mw_slot.valid !== 1'b1)
            begin errors++; $display("FAIL stream_mw got %h/%h/%b exp 8c220004/4/1", bus.mw_slot.instr, bus.mw_slot.npc, bus.mw_slot.valid); end
        checks++; if ({bus.emif_rs, bus.emif_rt, bus.emif_rd} !== {5'd5, 5'd6, 5'd4}) begin errors++; $display("FAIL stream_em_add got %h", {bus.emif_rs, bus.emif_rt, bus.emif_rd}); end
        checks++; if ({bus.deif_rs, bus.deif_rt, bus.deif_MemtoReg} !== {5'd2, 5'd3, 1'b1}) begin errors++; $display("FAIL stream_de got %h", {bus.deif_rs, bus.deif_rt, bus.deif_MemtoReg}); end
        checks++; if ({bus.fdif_rs, bus.fdif_rt} !== {5'd1, 5'd2}) begin errors++; $display("FAIL stream_fd got %h", {bus.fdif_rs, bus.fdif_rt}); end
        checks++; if (bus.pc !== 32'd16) begin errors++; $display("FAIL stream_pc got %h exp 10", bus.pc); end
    endtask

    task automatic test_stall();
        bus.fdif_stall  = 1'b1;
        bus.deif_stall  = 1'b1;
        bus.PCWrite     = 1'b0;
        bus.fetch_instr = 32'h1111_1111;
        bus.fetch_npc   = 32'h100;
        bus.next_pc     = 32'h100;
        bus.dec_ctrl    = 8'h08;
        step();
        checks++; if (bus.pc !== 32'd16) begin errors++; $display("FAIL stall_pc got %h exp 10", bus.pc); end
        checks++; if (bus.fd_instr !== 32'h1022_0003) begin errors++; $display("FAIL stall_fd got %h exp 10220003", bus.fd_instr); end
        checks++; if (bus.de_slot.instr !== 32'h8C43_0008 || bus.de_slot.valid !== 1'b1) begin errors++; $display("FAIL stall_de got %h/%b", bus.de_slot.instr, bus.de_slot.valid); end
        checks++; if (bus.em_slot !== BUBBLE_SLOT) begin errors++; $display("FAIL stall_em_bubble got valid %b instr %h", bus.em_slot.valid, bus.em_slot.instr); end
        checks++; if (bus.mw_slot.instr !== 32'h00A6_2020) begin errors++; $display("FAIL stall_mw got %h exp 00a62020", bus.mw_slot.instr); end
`ifdef PIPE_STATS_EN
        checks++; if (bus.bubble_cnt !== 32'd1) begin errors++; $display("FAIL stall_bubble_cnt got %0d exp 1", bus.bubble_cnt); end
`endif
        bus.fdif_stall = 1'b0;
        bus.deif_stall = 1'b0;
        bus.PCWrite    = 1'b1;
    endtask

    task automatic test_flush();
        bus.fetch_instr = 32'h2222_2222;
        bus.fetch_npc   = 32'd20;
        bus.next_pc     = 32'd20;
        bus.dec_ctrl    = 8'h08;
        step();
        checks++; if (bus.em_slot.instr !== 32'h8C43_0008 || bus.emif_beqS !== 1'b0) begin errors++; $display("FAIL flush_pre_em got %h/%b", bus.em_slot.instr, bus.emif_beqS); end
        bus.fdif_flush  = 1'b1;
        bus.deif_flush  = 1'b1;
        bus.emif_flush  = 1'b1;
        bus.fetch_instr = 32'h3333_3333;
        bus.next_pc     = 32'h40;
        step();
        checks++; if ({bus.fd_instr, bus.fd_npc} !== 64'h0) begin errors++; $display("FAIL flush_fd got %h", {bus.fd_instr, bus.fd_npc}); end
        checks++; if (bus.de_slot !== BUBBLE_SLOT || bus.em_slot !== BUBBLE_SLOT) begin errors++; $display("FAIL flush_de_em valid %b %b", bus.de_slot.valid, bus.em_slot.valid); end
        checks++; if (bus.mw_slot.instr !== 32'h8C43_0008 || bus.mw_slot.valid !== 1'b1) begin errors++; $display("FAIL flush_mw got %h/%b", bus.mw_slot.instr, bus.mw_slot.valid); end
        checks++; if (bus.pc !== 32'h40) begin errors++; $display("FAIL flush_pc got %h exp 40", bus.pc); end
`ifdef PIPE_STATS_EN
        checks++; if ({bus.bubble_cnt, bus.flush_cnt} !== {32'd1, 32'd1}) begin errors++; $display("FAIL flush_cnts got %0d/%0d exp 1/1", bus.bubble_cnt, bus.flush_cnt); end
`endif
        bus.fdif_flush = 1'b0;
        bus.deif_flush = 1'b0;
        bus.emif_flush = 1'b0;
    endtask

    task automatic test_flush_stall();
        bus.fetch_instr = 32'h4444_4444; bus.fetch_npc = 32'h44; bus.next_pc = 32'h44; bus.dec_ctrl = 8'h00;
        step();
        bus.fetch_instr = 32'h5555_5555; bus.fetch_npc = 32'h48; bus.next_pc = 32'h48; bus.dec_ctrl = 8'h80;
        step();
        bus.deif_flush  = 1'b1;
        bus.deif_stall  = 1'b1;
        bus.fetch_instr = 32'h6666_6666; bus.fetch_npc = 32'h4C; bus.next_pc = 32'h4C; bus.dec_ctrl = 8'h00;
        step();
        checks++; if (bus.de_slot !== BUBBLE_SLOT) begin errors++; $display("FAIL fs_de got valid %b instr %h exp bubble", bus.de_slot.valid, bus.de_slot.instr); end
        checks++; if (bus.em_slot.instr !== 32'h4444_4444 || bus.em_slot.valid !== 1'b1) begin errors++; $display("FAIL fs_em got %h/%b", bus.em_slot.instr, bus.em_slot.valid); end
`ifdef PIPE_STATS_EN
        checks++; if ({bus.bubble_cnt, bus.flush_cnt} !== {32'd1, 32'd2}) begin errors++; $display("FAIL fs_cnts got %0d/%0d exp 1/2", bus.bubble_cnt, bus.flush_cnt); end
`endif
        bus.deif_flush = 1'b0;
        bus.deif_stall = 1'b0;
    endtask

    task automatic test_freeze();
        bus.pipe_en     = 1'b0;
        bus.emif_flush  = 1'b1;
        bus.fdif_stall  = 1'b1;
        bus.fetch_instr = 32'h7777_7777;
        bus.next_pc     = 32'h99;
        step();
        step();
        checks++; if (bus.pc !== 32'h4C) begin errors++; $display("FAIL frz_pc got %h exp 4c", bus.pc); end
        checks++; if (bus.fd_instr !== 32'h6666_6666) begin errors++; $display("FAIL frz_fd got %h exp 66666666", bus.fd_instr); end
        checks++; if (bus.de_slot.valid !== 1'b0) begin errors++; $display("FAIL frz_de got valid %b exp 0", bus.de_slot.valid); end
        checks++; if (bus.em_slot.instr !== 32'h4444_4444 || bus.emif_RegWr !== 1'b1) begin errors++; $display("FAIL frz_em got %h/%b", bus.em_slot.instr, bus.emif_RegWr); end
        checks++; if (bus.mw_slot.valid !== 1'b1 || bus.mw_slot.instr !== 32'h0) begin errors++; $display("FAIL frz_mw got %h/%b", bus.mw_slot.instr, bus.mw_slot.valid); end
`ifdef PIPE_STATS_EN
        checks++; if (bus.flush_cnt !== 32'd2) begin errors++; $display("FAIL frz_flush_cnt got %0d exp 2", bus.flush_cnt); end
`endif
        set_idle();
    endtask

    task automatic test_reset_mid();
        #2;
        nRST = 1'b0;
        #1;
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL rmid_pc got %h exp 0", bus.pc); end
        checks++; if (bus.fd_instr !== 32'h0) begin errors++; $display("FAIL rmid_fd got %h exp 0", bus.fd_instr); end
        checks++; if ({bus.de_slot.valid, bus.em_slot.valid, bus.mw_slot.valid} !== 3'b000 || bus.em_slot !== BUBBLE_SLOT)
            begin errors++; $display("FAIL rmid_slots valid %b%b%b", bus.de_slot.valid, bus.em_slot.valid, bus.mw_slot.valid); end
        checks++; if (hz_taps() !== 55'h0) begin errors++; $display("FAIL rmid_hz got %h exp 0", hz_taps()); end
`ifdef PIPE_STATS_EN
        checks++; if ({bus.bubble_cnt, bus.flush_cnt} !== 64'h0) begin errors++; $display("FAIL rmid_cnt got %h exp 0", {bus.bubble_cnt, bus.flush_cnt}); end
`endif
        @(negedge CLK);
        nRST = 1'b1;
        bus.fetch_instr = 32'h8C22_0004; bus.fetch_npc = 32'd4; bus.next_pc = 32'd4;
        step();
        checks++; if (bus.fd_instr !== 32'h8C22_0004 || bus.pc !== 32'd4) begin errors++; $display("FAIL rmid_restart got %h/%h", bus.fd_instr, bus.pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_stall();
        test_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
